if_fetch: RTL and testbench

Instruction fetch stage. It sits directly upstream of the IF/ID pipeline register and drives its instr_i/pc_i inputs.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory with a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them in order with their PCs.
- Handles hazard stalls and branch/jump redirects from EX, including discarding responses to in-flight requests.

---
 rtl/if_fetch.sv | 107 ++++++++++
 tb/tb_if_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues req/gnt/rvalid word requests,
// and buffers in-order responses with their PCs ahead of the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int          AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] drop_cnt_q;

    logic [CW:0]   credit_used;
    logic [31:0]   redirect_aligned;
    logic          issue;
    logic          rsp;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    // Credits cover both in-flight requests and buffered entries, so the FIFO can never overflow.
    assign credit_used      = {1'b0, outstanding_q} + {1'b0, count_q};
    assign redirect_aligned = redirect_pc_i & ~32'h0000_0003;
    assign fifo_empty       = (count_q == '0);

    assign imem_req_o  = !redirect_valid_i && (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr_o = pc_q;

    assign issue    = imem_req_o && imem_gnt_i;
    assign rsp      = imem_rvalid_i && (outstanding_q != '0);
    assign rsp_drop = rsp && (drop_cnt_q != '0);
    assign push     = rsp && (drop_cnt_q == '0) && !redirect_valid_i;
    assign pop      = !fifo_empty && !stall_i;

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? NOP   : instr_mem[rd_ptr_q];
    assign pc_o          = fifo_empty ? 32'h0 : pc_mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else if (redirect_valid_i) begin
            // A response landing this cycle is consumed here, so it is not counted again in drop_cnt.
            pc_q          <= redirect_aligned;
            resp_pc_q     <= redirect_aligned;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= outstanding_q - CW'(rsp);
            drop_cnt_q    <= outstanding_q - CW'(rsp);
        end else begin
            if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            outstanding_q <= outstanding_q + CW'(issue) - CW'(rsp);
            if (rsp_drop) begin
                drop_cnt_q <= drop_cnt_q - CW'(1);
            end
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + AW'(1);
                resp_pc_q <= resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: cycle table for streaming/stall, hand sequences for
// redirects, grant backpressure and mid-stream reset, against an in-order memory model.
module tb_if_fetch;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat   = 1;
    int          cyc_n = 0;
    logic [31:0] exp_next = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t rsp_q[$];

    // In-order memory: response for a grant in cycle N appears in cycle N+lat, data = addr | A000_0000.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk_i);
            if (rst_i) begin
                rsp_q.delete();
            end else begin
                if (imem_rvalid_i && rsp_q.size() > 0) void'(rsp_q.pop_front());
                if (imem_req_o && imem_gnt_i) rsp_q.push_back('{imem_addr_o, cyc_n + lat});
            end
            cyc_n++;
            #1;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_n) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = rsp_q[0].addr | 32'hA000_0000;
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'h0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the edge, sample at the falling edge, then track in-order pops.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rp, input logic g);
        @(posedge clk_i);
        #1;
        rst_i            = 1'b0;
        stall_i          = st;
        redirect_valid_i = rd;
        redirect_pc_i    = rp;
        imem_gnt_i       = g;
        @(negedge clk_i);
        check("credit_cap", 32'(int'(dut.outstanding_q) + int'(dut.count_q) <= 2), 32'd1);
        if (instr_valid_o && !stall_i && !redirect_valid_i) begin
            check("order_pc", pc_o, exp_next);
            check("order_instr", instr_o, exp_next | 32'hA000_0000);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i            = 1'b1;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_gnt_i       = 1'b1;
        exp_next         = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", 32'(imem_req_o), 32'd1);
        check("rst_addr", imem_addr_o, 32'h0);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc, input int budget);
        int n = 0;
        while (!instr_valid_o && n < budget) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check({name, "_seen"}, 32'(instr_valid_o), 32'd1);
        check({name, "_pc"}, pc_o, exp_pc);
        check({name, "_instr"}, instr_o, exp_pc | 32'hA000_0000);
    endtask

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [31:0] exp_instr;

        tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'd8,  1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b0, 32'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b0, 32'd0};
        for (int i = 8; i < 14; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 32'd24, 1'b1, 32'd16};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 32'd24, 1'b1, 32'd16};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd20};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 32'd28, 1'b0, 32'd0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 32'd32, 1'b1, 32'd24};

        rst_i            = 1'b1;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_gnt_i       = 1'b1;

        // Streaming at latency 1, then a 6-cycle stall that fills the buffer.
        lat = 1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].stall, 1'b0, 32'h0, tbl[i].gnt);
            exp_instr = tbl[i].exp_valid ? (tbl[i].exp_pc | 32'hA000_0000) : 32'h0000_0013;
            check($sformatf("tbl%0d_req", i), 32'(imem_req_o), 32'(tbl[i].exp_req));
            check($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].exp_pc);
            check($sformatf("tbl%0d_instr", i), instr_o, exp_instr);
        end

        // Redirect with two requests in flight at latency 3.
        lat = 3;
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h100, 1'b1);
        check("redir_req", 32'(imem_req_o), 32'd0);
        exp_next = 32'h100;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_addr", imem_addr_o, 32'h100);
        check("redir_flush", 32'(instr_valid_o), 32'd0);
        wait_valid("redir", 32'h100, 20);

        // Misaligned redirect that coincides with a response arriving.
        lat = 3;
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("mis_pre_req", 32'(imem_req_o), 32'd0);
        cyc(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        check("mis_rvalid_same_cycle", 32'(imem_rvalid_i), 32'd1);
        check("mis_req", 32'(imem_req_o), 32'd0);
        exp_next = 32'h100;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("mis_addr", imem_addr_o, 32'h100);
        check("mis_req_after", 32'(imem_req_o), 32'd1);
        wait_valid("mis", 32'h100, 20);

        // Grant withheld: address must hold until accepted.
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            check("nognt_req", 32'(imem_req_o), 32'd1);
            check("nognt_addr", imem_addr_o, 32'h0);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("gnt_addr", imem_addr_o, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_gnt_addr", imem_addr_o, 32'h4);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 32'h200, 1'b1);
        check("stallredir_pre_valid", 32'(instr_valid_o), 32'd1);
        check("stallredir_req", 32'(imem_req_o), 32'd0);
        exp_next = 32'h200;
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("stallredir_flush", 32'(instr_valid_o), 32'd0);
        check("stallredir_addr", imem_addr_o, 32'h200);
        wait_valid("stallredir", 32'h200, 20);

        // Reset pulsed with the buffer full.
        lat = 1;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("full_valid", 32'(instr_valid_o), 32'd1);
        check("full_req", 32'(imem_req_o), 32'd0);
        check("full_addr", imem_addr_o, 32'h8);
        @(posedge clk_i);
        #1;
        rst_i    = 1'b1;
        exp_next = 32'h0;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        stall_i = 1'b0;
        @(negedge clk_i);
        check("midrst_valid", 32'(instr_valid_o), 32'd0);
        check("midrst_instr", instr_o, 32'h0000_0013);
        check("midrst_pc", pc_o, 32'h0);
        check("midrst_addr", imem_addr_o, 32'h0);
        check("midrst_req", 32'(imem_req_o), 32'd1);
        wait_valid("refetch", 32'h0, 20);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("refetch_progress", 32'(exp_next >= 32'h10), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
